// File: rtl/ip_codma_mem_arbiter.sv
// Two-requester arbiter in front of one shared memory slave.
// One transaction at a time: address phase to slave grant, then 1/2/4 data beats.
module ip_codma_mem_arbiter #(
  parameter int RR_ENABLE = 1
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic [1:0]   i_m_read,
  input  logic [1:0]   i_m_write,
  input  logic [63:0]  i_m_addr,
  input  logic [7:0]   i_m_size,
  input  logic [127:0] i_m_write_data,
  input  logic [1:0]   i_m_write_valid,
  output logic [1:0]   o_m_grant,
  output logic [63:0]  o_m_read_data,
  output logic [1:0]   o_m_read_valid,
  output logic [1:0]   o_m_error,
  output logic         o_s_read,
  output logic         o_s_write,
  output logic [31:0]  o_s_addr,
  output logic [3:0]   o_s_size,
  output logic [63:0]  o_s_write_data,
  output logic         o_s_write_valid,
  input  logic         i_s_grant,
  input  logic [63:0]  i_s_read_data,
  input  logic         i_s_read_valid,
  input  logic         i_s_error
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t     r_state, w_state_nx;
  logic       r_owner, w_owner_nx;
  logic       r_last_winner, w_last_winner_nx;
  logic       r_dir, w_dir_nx;            // 1 = write
  logic [2:0] r_beats, w_beats_nx;

  logic [1:0]  w_pend;
  logic        w_own_rd, w_own_wr, w_beat;
  logic [31:0] w_own_addr;
  logic [3:0]  w_own_size;
  logic [63:0] w_own_wdata;

  assign w_pend      = i_m_read | i_m_write;
  assign w_own_rd    = i_m_read[r_owner];
  assign w_own_wr    = i_m_write[r_owner];
  assign w_own_addr  = r_owner ? i_m_addr[63:32]        : i_m_addr[31:0];
  assign w_own_size  = r_owner ? i_m_size[7:4]          : i_m_size[3:0];
  assign w_own_wdata = r_owner ? i_m_write_data[127:64] : i_m_write_data[63:0];
  // A beat only counts in the direction latched at grant time.
  assign w_beat      = r_dir ? i_m_write_valid[r_owner] : i_s_read_valid;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_owner       <= 1'b0;
      r_last_winner <= 1'b1;
      r_dir         <= 1'b0;
      r_beats       <= 3'd0;
    end else begin
      r_state       <= w_state_nx;
      r_owner       <= w_owner_nx;
      r_last_winner <= w_last_winner_nx;
      r_dir         <= w_dir_nx;
      r_beats       <= w_beats_nx;
    end
  end

  always_comb begin
    w_state_nx       = r_state;
    w_owner_nx       = r_owner;
    w_last_winner_nx = r_last_winner;
    w_dir_nx         = r_dir;
    w_beats_nx       = r_beats;
    o_m_grant        = 2'b00;
    o_m_read_data    = 64'd0;
    o_m_read_valid   = 2'b00;
    o_m_error        = 2'b00;
    o_s_read         = 1'b0;
    o_s_write        = 1'b0;
    o_s_addr         = 32'd0;
    o_s_size         = 4'd0;
    o_s_write_data   = 64'd0;
    o_s_write_valid  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (|w_pend) begin
          w_state_nx = S_ADDR;
          if (&w_pend) w_owner_nx = (RR_ENABLE != 0) ? ~r_last_winner : 1'b0;
          else         w_owner_nx = w_pend[1];
        end
      end
      S_ADDR: begin
        o_s_read  = w_own_rd;
        o_s_write = w_own_wr & ~w_own_rd;
        o_s_addr  = w_own_addr;
        o_s_size  = w_own_size;
        if (i_s_error) begin
          o_m_error[r_owner] = 1'b1;
          w_last_winner_nx   = r_owner;
          w_state_nx         = S_IDLE;
        end else if (!(w_own_rd || w_own_wr)) begin
          w_state_nx = S_IDLE;   // withdrawn request does not count as a win
        end else if (i_s_grant) begin
          o_m_grant[r_owner] = 1'b1;
          w_dir_nx           = ~w_own_rd;
          w_state_nx         = S_DATA;
          case (w_own_size)
            4'd2:    w_beats_nx = 3'd2;
            4'd4:    w_beats_nx = 3'd4;
            default: w_beats_nx = 3'd1;
          endcase
        end
      end
      S_DATA: begin
        if (r_dir) begin
          o_s_write_data  = w_own_wdata;
          o_s_write_valid = i_m_write_valid[r_owner];
        end else begin
          o_m_read_data           = i_s_read_data;
          o_m_read_valid[r_owner] = i_s_read_valid;
        end
        if (i_s_error) begin
          o_m_error[r_owner] = 1'b1;
          w_last_winner_nx   = r_owner;
          w_state_nx         = S_IDLE;
        end else if (w_beat) begin
          w_beats_nx = r_beats - 3'd1;
          if (r_beats == 3'd1) begin
            w_last_winner_nx = r_owner;
            w_state_nx       = S_IDLE;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

endmodule

// File: doc/ip_codma_mem_arbiter.md
IP_CODMA_MEM_ARBITER -- requirements
Module: ip_codma_mem_arbiter

Interface
REQ-001 The block SHALL have parameter RR_ENABLE, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with requester 0 highest.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clock  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 m_read  in  2  per-requester read address-phase request, bit i = requester i.
REQ-005 m_write  in  2  per-requester write address-phase request.
REQ-006 m_addr  in  64  {m1,m0} 32-bit target addresses.
REQ-007 m_size  in  8  {m1,m0} 4-bit sizes, where 1, 2 and 4 are double-word counts.
REQ-008 m_write_data  in  128  {m1,m0} 64-bit write data.
REQ-009 m_write_valid  in  2  per-requester write beat valid.
REQ-010 m_grant  out  2  per-requester address-phase end.
REQ-011 m_read_data  out  64  read data, broadcast to both requesters.
REQ-012 m_read_valid  out  2  per-requester read beat valid.
REQ-013 m_error  out  2  per-requester transaction error.
REQ-014 s_read  out  1  read request to the shared slave.
REQ-015 s_write  out  1  write request to the shared slave.
REQ-016 s_addr  out  32  address to the slave.
REQ-017 s_size  out  4  size to the slave.
REQ-018 s_write_data  out  64  write data to the slave.
REQ-019 s_write_valid  out  1  write beat valid to the slave.
REQ-020 s_grant  in  1  grant from the slave.
REQ-021 s_read_data  in  64  read data from the slave.
REQ-022 s_read_valid  in  1  read beat valid from the slave.
REQ-023 s_error  in  1  error from the slave.

Function
REQ-024 The FSM SHALL have states IDLE, ADDR and DATA, plus registers owner (1b), last_winner (1b), dir (read/write) and beats (3b).
REQ-025 In IDLE, requester i is pending if m_read[i]|m_write[i]; with none pending stay IDLE, with one pending take it, with both pending take ~last_winner (RR_ENABLE=1) or 0 (RR_ENABLE=0); latch owner and go to ADDR.
REQ-026 Latency SHALL be: request first seen in IDLE at cycle N -> s_read/s_write high in cycle N+1.
REQ-027 In ADDR, s_read = m_read[owner], s_write = m_write[owner] & ~m_read[owner] (read wins if both are set), and s_addr/s_size = owner slice, all combinational.
REQ-028 In ADDR with s_grant=1, m_grant[owner]=1 in the same cycle; latch dir; load beats = 1/2/4 for size 1/2/4, any other size -> 1; go to DATA.
REQ-029 In ADDR, if the owner drops both requests before grant, go to IDLE with last_winner unchanged.
REQ-030 In DATA, s_read=s_write=0; read: m_read_data=s_read_data, m_read_valid[owner]=s_read_valid; write: s_write_data=owner slice, s_write_valid=m_write_valid[owner].
REQ-031 Each valid beat in the latched direction SHALL decrement beats; on the beat with beats=1, go to IDLE and set last_winner<=owner.
REQ-032 s_error in ADDR or DATA SHALL drive m_error[owner]=1 the same cycle and go to IDLE immediately, ignoring remaining beats; set last_winner<=owner; error SHALL win over a simultaneous grant or last beat.
REQ-033 The non-owner's m_grant, m_read_valid and m_error SHALL be 0 at all times; in IDLE all s_* outputs and all m_* outputs SHALL be 0 (m_read_data may be 0).
REQ-034 At least one IDLE cycle SHALL separate the last beat/error of one transaction from the next address phase.

Reset
REQ-035 While reset=1 at an edge: state<=IDLE, owner<=0, last_winner<=1, beats<=0; all outputs SHALL be 0 in the following cycle.
REQ-036 Reset asserted mid-ADDR/DATA SHALL abandon the transaction with no m_error pulse; the slave request drops after that edge.

Verification
REQ-037 Both requesters raise read, size=1, at the same time after reset -> m0 is granted first; m1's address phase starts 1 cycle after m0's single read_valid beat.
REQ-038 m0 write size=4, s_grant at ADDR cycle 2, 4 write_valid beats with stalls -> s_write_valid mirrors m0 exactly 4 times, then IDLE.
REQ-039 m0 and m1 continuously request with RR_ENABLE=1 -> grants alternate 0,1,0,1; with RR_ENABLE=0 -> m0 is always granted.
REQ-040 s_error on the 2nd beat of a size=4 read by m1 -> m_error=2'b10 that cycle, FSM in IDLE next cycle, m_read_valid[0] never set.
REQ-041 reset during beat 2 of a size=2 write -> all outputs are 0 the next cycle, and a new m1 request is served normally.
